// File: rtl/pe_array_if.sv
// Operand/result bundle for the systolic PE array: fire strobe, edge operands,
// and the parallel accumulator outputs.
interface pe_array_if #(
  parameter int unsigned rows   = 4,
  parameter int unsigned cols   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 12
);
  logic              fire;
  logic [DATA_W-1:0] in_w [0:cols-1];
  logic [DATA_W-1:0] in_a [0:rows-1];
  logic [ACC_W-1:0]  outs [0:rows*cols-1];

  modport master (output fire, in_w, in_a, input outs);
  modport slave  (input fire, in_w, in_a, output outs);
endinterface

// File: rtl/pe_array.sv
// Output-stationary rows x cols MAC array: activations flow right, weights flow
// down, every PE keeps a wrapping unsigned accumulator exposed in parallel.
module pe_array_pe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_fire,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_w,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_w,
  output logic [ACC_W-1:0]  o_acc
);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = (ACC_W > PROD_W) ? ACC_W : PROD_W;

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_w;
  logic [ACC_W-1:0]  r_acc;
  logic [PROD_W-1:0] w_prod;
  logic [SUM_W-1:0]  w_sum;

  assign w_prod = PROD_W'(i_a) * PROD_W'(i_w);
  assign w_sum  = SUM_W'(r_acc) + SUM_W'(w_prod);

  // rstn is active-high here: 1 clears the PE immediately
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_a   <= '0;
      r_w   <= '0;
      r_acc <= '0;
    end else if (i_fire) begin
      r_a   <= i_a;
      r_w   <= i_w;
      r_acc <= ACC_W'(w_sum);
    end
  end

  assign o_a   = r_a;
  assign o_w   = r_w;
  assign o_acc = r_acc;
endmodule

module pe_array #(
  parameter int unsigned rows   = 4,
  parameter int unsigned cols   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 12
) (
  input logic          clk,
  input logic          rstn,
  pe_array_if.slave    bus
);
  logic [DATA_W-1:0] w_a_q [rows][cols];
  logic [DATA_W-1:0] w_w_q [rows][cols];
  logic [ACC_W-1:0]  w_acc [rows][cols];

  // Operands leaving the right/bottom edges have no consumer
  logic [rows-1:0] w_unused_a;
  logic [cols-1:0] w_unused_w;

  for (genvar r = 0; r < rows; r++) begin : g_row
    assign w_unused_a[r] = ^w_a_q[r][cols-1];
    for (genvar c = 0; c < cols; c++) begin : g_col
      logic [DATA_W-1:0] w_a_in;
      logic [DATA_W-1:0] w_w_in;

      if (c == 0) begin : g_a_edge
        assign w_a_in = bus.in_a[r];
      end else begin : g_a_chain
        assign w_a_in = w_a_q[r][c-1];
      end

      if (r == 0) begin : g_w_edge
        assign w_w_in = bus.in_w[c];
      end else begin : g_w_chain
        assign w_w_in = w_w_q[r-1][c];
      end

      pe_array_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk    (clk),
        .rstn   (rstn),
        .i_fire (bus.fire),
        .i_a    (w_a_in),
        .i_w    (w_w_in),
        .o_a    (w_a_q[r][c]),
        .o_w    (w_w_q[r][c]),
        .o_acc  (w_acc[r][c])
      );

      assign bus.outs[r*cols+c] = w_acc[r][c];
    end
  end

  for (genvar c = 0; c < cols; c++) begin : g_wsink
    assign w_unused_w[c] = ^w_w_q[rows-1][c];
  end
endmodule

// File: tb/tb_pe_array.sv
// Self-checking bench for pe_array: directed vector table, async reset sequence,
// and random traffic against an input-history model of the array.
module tb_pe_array;
  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 12;
  localparam int unsigned NPE  = ROWS * COLS;
  localparam int unsigned HMAX = 1024;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  pe_array_if #(.rows(ROWS), .cols(COLS), .DATA_W(DW), .ACC_W(AW)) bus ();

  pe_array #(.rows(ROWS), .cols(COLS), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Model: operand history per enabled edge since reset; PE(r,c) on edge k
  // sees in_a[r] from edge k-c and in_w[c] from edge k-r.
  int unsigned hist_a [HMAX][ROWS];
  int unsigned hist_w [HMAX][COLS];
  int unsigned m_acc  [NPE];
  int          n_edges;

  function automatic void model_reset();
    n_edges = 0;
    for (int i = 0; i < int'(NPE); i++) m_acc[i] = 0;
  endfunction

  function automatic void model_edge();
    int k;
    if (rstn) begin
      model_reset();
      return;
    end
    if (!bus.fire) return;
    if (n_edges >= int'(HMAX)) begin
      $display("FAIL model_history_overflow got=%0d want<%0d", n_edges, HMAX);
      $fatal(1);
    end
    k = n_edges;
    for (int r = 0; r < int'(ROWS); r++) hist_a[k][r] = int'(bus.in_a[r]);
    for (int c = 0; c < int'(COLS); c++) hist_w[k][c] = int'(bus.in_w[c]);
    n_edges++;
    for (int r = 0; r < int'(ROWS); r++)
      for (int c = 0; c < int'(COLS); c++)
        if (k >= r && k >= c)
          m_acc[r*COLS+c] = (m_acc[r*COLS+c] + hist_a[k-c][r] * hist_w[k-r][c]) % (1 << AW);
  endfunction

  function automatic void check(string name, int idx, int unsigned got, int unsigned exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s outs[%0d] got=%0d want=%0d t=%0t", name, idx, got, exp, $time);
  endfunction

  task automatic check_model(string name);
    for (int i = 0; i < int'(NPE); i++) check(name, i, int'(bus.outs[i]), m_acc[i]);
  endtask

  task automatic check_zero(string name);
    for (int i = 0; i < int'(NPE); i++) check(name, i, int'(bus.outs[i]), 0);
  endtask

  task automatic set_inputs(bit fire, int unsigned w, int unsigned a, bit lane0);
    bus.fire = fire;
    for (int c = 0; c < int'(COLS); c++) bus.in_w[c] = (lane0 && c != 0) ? '0 : DW'(w);
    for (int r = 0; r < int'(ROWS); r++) bus.in_a[r] = (lane0 && r != 0) ? '0 : DW'(a);
  endtask

  task automatic set_random();
    for (int c = 0; c < int'(COLS); c++) bus.in_w[c] = DW'($urandom_range(0, 255));
    for (int r = 0; r < int'(ROWS); r++) bus.in_a[r] = DW'($urandom_range(0, 255));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    bit          rst;
    bit          fire;
    int unsigned w;
    int unsigned a;
    bit          lane0;
    int          idx;
    int unsigned exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, bit fire, int unsigned w, int unsigned a,
                              bit lane0, int idx, int unsigned exp);
    vec_t v;
    v.rst = rst; v.fire = fire; v.w = w; v.a = a; v.lane0 = lane0; v.idx = idx; v.exp = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    // Single MAC on PE(0,0), then zeros: neighbours must stay 0
    add(0, 1, 3, 5, 1, 0, 15);
    add(0, 1, 0, 0, 0, 0, 15);
    add(0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 4, 0);
    add(0, 1, 0, 0, 0, 5, 0);
    // Ramp of ones for 10 enabled edges
    add(1, 1, 9, 9, 0, 0, 0);
    for (int k = 1; k <= 10; k++) add(0, 1, 1, 1, 0, 0, k);
    // Hold with fire=0 and garbage inputs
    add(0, 0, 9, 9, 0, 0, 10);
    add(0, 0, 9, 9, 0, 5, 9);
    add(0, 0, 9, 9, 0, 3, 7);
    add(0, 0, 9, 9, 0, 15, 7);
    add(0, 0, 9, 9, 0, 12, 7);
    // Pipelined ones drain into PE(3,3)
    add(0, 1, 0, 0, 0, 15, 8);
    // Accumulator wrap
    add(1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 255, 255, 0, 0, 3585);
    add(0, 1, 255, 255, 0, 0, 3074);

    // Reset holds everything at 0 regardless of fire and inputs
    model_reset();
    rstn = 1'b1;
    bus.fire = 1'b1;
    set_random();
    #1;
    check_zero("reset_initial");
    repeat (3) begin
      set_random();
      @(posedge clk);
      #1;
      check_zero("reset_after_edge");
      @(negedge clk);
      check_zero("reset_between_edges");
    end

    foreach (vecs[i]) begin
      rstn = vecs[i].rst;
      set_inputs(vecs[i].fire, vecs[i].w, vecs[i].a, vecs[i].lane0);
      tick();
      check($sformatf("vec%0d", i), vecs[i].idx, int'(bus.outs[vecs[i].idx]), vecs[i].exp);
      check_model($sformatf("vec%0d_model", i));
    end

    // Asynchronous reset mid-ramp clears before the next edge
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    set_inputs(1, 1, 1, 0);
    repeat (4) tick();
    check_model("ramp_pre_async");
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    #1;
    check_zero("async_reset");
    #2;
    rstn = 1'b0;
    set_inputs(1, 2, 2, 1);
    tick();
    check("post_async_mac", 0, int'(bus.outs[0]), 4);
    check_model("post_async_model");

    // Random traffic with random fire gaps and occasional reset
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 300; i++) begin
      rstn = ($urandom_range(0, 49) == 0);
      bus.fire = ($urandom_range(0, 3) != 0);
      set_random();
      tick();
      check_model("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
